// File: rtl/dphy_master_tx.sv
// rtl/dphy_master_tx.sv - D-PHY data-lane HS burst sequencer for the CSI-2 TX path
//
// Sequences every data lane through LP-11, LP-01, LP-00, HS-zero, the 0xB8 sync
// byte, payload, HS-trail and LP-11 exit. All lanes carry identical LP states.
// Every output is a register that changes on the edge entering a state.
//
// Ports:
//   clk_i       byte clock
//   rst_i       asynchronous active-low reset
//   enable_i    permits a new burst; only looked at in IDLE
//   data_i      payload word, lane i carries byte i
//   valid_i     data_i valid
//   last_i      data_i is the final word of the burst
//   ready_o     word taken on an edge with valid_i && ready_o
//   hs_data_o   HS byte per lane (LSB serialized first)
//   hs_en_o     HS drivers enabled
//   lp_p_o      LP Dp level per lane
//   lp_n_o      LP Dn level per lane
//   busy_o      high outside IDLE
//   underrun_o  one-cycle pulse when the stream bubbles mid-burst

module dphy_master_tx #(
  parameter int DATA_LANES     = 2,
  parameter int LPX_CYCLES     = 4,
  parameter int PREPARE_CYCLES = 3,
  parameter int HS_ZERO_CYCLES = 10,
  parameter int TRAIL_CYCLES   = 4,
  parameter int EXIT_CYCLES    = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [DATA_LANES-1:0][7:0]  data_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic [DATA_LANES-1:0][7:0]  hs_data_o,
  output logic                        hs_en_o,
  output logic [DATA_LANES-1:0]       lp_p_o,
  output logic [DATA_LANES-1:0]       lp_n_o,
  output logic                        busy_o,
  output logic                        underrun_o
);

  localparam int MAX_A = (LPX_CYCLES > PREPARE_CYCLES) ? LPX_CYCLES : PREPARE_CYCLES;
  localparam int MAX_B = (HS_ZERO_CYCLES > TRAIL_CYCLES) ? HS_ZERO_CYCLES : TRAIL_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > EXIT_CYCLES) ? MAX_C : EXIT_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);

  // LAST shows the final accepted word for one cycle with ready low,
  // before the trail is derived from it.
  typedef enum logic [3:0] {
    IDLE, LP01, LP00, HS_ZERO, SYNC, DATA, LAST, TRAIL, EXIT
  } state_t;

  state_t                      state_q, state_n;
  logic [CW-1:0]               cnt_q, cnt_n;
  logic [DATA_LANES-1:0][7:0]  hs_data_n, trail_pat;
  logic [DATA_LANES-1:0]       lp_p_n, lp_n_n;
  logic                        hs_en_n, ready_n, busy_n, underrun_n;

  // Trail level is the inverse of the last serialized bit (bit 7) of the byte
  // currently held on each lane.
  always_comb begin
    trail_pat = '0;
    for (int i = 0; i < DATA_LANES; i++) begin
      trail_pat[i] = {8{~hs_data_o[i][7]}};
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    hs_data_n  = hs_data_o;
    hs_en_n    = hs_en_o;
    lp_p_n     = lp_p_o;
    lp_n_n     = lp_n_o;
    ready_n    = 1'b0;
    busy_n     = 1'b1;
    underrun_n = 1'b0;
    case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (enable_i && valid_i) begin
          state_n = LP01;
          cnt_n   = CW'(LPX_CYCLES - 1);
          lp_p_n  = '0;
          lp_n_n  = '1;
          busy_n  = 1'b1;
        end
      end
      LP01: begin
        if (cnt_q == '0) begin
          state_n = LP00;
          cnt_n   = CW'(PREPARE_CYCLES - 1);
          lp_p_n  = '0;
          lp_n_n  = '0;
        end
      end
      LP00: begin
        if (cnt_q == '0) begin
          state_n   = HS_ZERO;
          cnt_n     = CW'(HS_ZERO_CYCLES - 1);
          hs_en_n   = 1'b1;
          hs_data_n = '0;
        end
      end
      HS_ZERO: begin
        if (cnt_q == '0) begin
          state_n   = SYNC;
          hs_data_n = {DATA_LANES{8'hB8}};
          ready_n   = 1'b1;
        end
      end
      SYNC, DATA: begin
        if (valid_i) begin
          hs_data_n = data_i;
          if (last_i) begin
            state_n = LAST;
          end else begin
            state_n = DATA;
            ready_n = 1'b1;
          end
        end else begin
          state_n    = TRAIL;
          cnt_n      = CW'(TRAIL_CYCLES - 1);
          hs_data_n  = trail_pat;
          underrun_n = 1'b1;
        end
      end
      LAST: begin
        state_n   = TRAIL;
        cnt_n     = CW'(TRAIL_CYCLES - 1);
        hs_data_n = trail_pat;
      end
      TRAIL: begin
        if (cnt_q == '0) begin
          state_n   = EXIT;
          cnt_n     = CW'(EXIT_CYCLES - 1);
          hs_en_n   = 1'b0;
          hs_data_n = '0;
          lp_p_n    = '1;
          lp_n_n    = '1;
        end
      end
      EXIT: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hs_data_o  <= '0;
      hs_en_o    <= 1'b0;
      lp_p_o     <= '1;
      lp_n_o     <= '1;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      hs_data_o  <= hs_data_n;
      hs_en_o    <= hs_en_n;
      lp_p_o     <= lp_p_n;
      lp_n_o     <= lp_n_n;
      ready_o    <= ready_n;
      busy_o     <= busy_n;
      underrun_o <= underrun_n;
    end
  end

endmodule

// File: tb/tb_dphy_master_tx.sv
// tb/tb_dphy_master_tx.sv - directed bench for dphy_master_tx with default parameters
module tb_dphy_master_tx;

  localparam int LANES = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   enable_i;
  logic [LANES-1:0][7:0]  data_i;
  logic                   valid_i;
  logic                   last_i;
  logic                   ready_o;
  logic [LANES-1:0][7:0]  hs_data_o;
  logic                   hs_en_o;
  logic [LANES-1:0]       lp_p_o;
  logic [LANES-1:0]       lp_n_o;
  logic                   busy_o;
  logic                   underrun_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] words [0:2];

  dphy_master_tx dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .ready_o    (ready_o),
    .hs_data_o  (hs_data_o),
    .hs_en_o    (hs_en_o),
    .lp_p_o     (lp_p_o),
    .lp_n_o     (lp_n_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ctl vector = {lp_p[1:0], lp_n[1:0], hs_en, ready, busy, underrun}
  function automatic logic [31:0] ctl_now();
    return 32'({lp_p_o, lp_n_o, hs_en_o, ready_o, busy_o, underrun_o});
  endfunction

  // Runs one burst starting at the current negedge. n_send words are offered;
  // without use_last the stream stops after them (underrun). Expected timeline
  // with defaults: LP01 1-4, LP00 5-7, HS_ZERO 8-17, SYNC 18, words 19.., then
  // 4 trail cycles, 6 exit cycles and IDLE.
  task automatic run_burst(input int n_send, input bit use_last, input logic [15:0] trail,
                           input bit hold, input logic [15:0] next_word, input string name);
    int          w    = 0;
    bit          seen = 0;
    int          ur   = use_last ? 0 : 1;
    int          tend = 19 + n_send;
    logic [1:0]  elp_p, elp_n;
    logic        ehen, erdy, ebusy, eur;
    logic [15:0] ehs;
    enable_i = 1'b1;
    valid_i  = 1'b1;
    data_i   = words[0];
    last_i   = use_last && (n_send == 1);
    for (int c = 1; c <= tend + 10; c++) begin
      @(negedge clk_i);
      elp_p = 2'b11; elp_n = 2'b11; ehen = 1'b0; erdy = 1'b0;
      ebusy = 1'b1;  eur = 1'b0;    ehs = 16'h0000;
      if (c <= 4) begin
        elp_p = 2'b00;
      end else if (c <= 7) begin
        elp_p = 2'b00; elp_n = 2'b00;
      end else if (c <= 17) begin
        elp_p = 2'b00; elp_n = 2'b00; ehen = 1'b1;
      end else if (c < tend) begin
        elp_p = 2'b00; elp_n = 2'b00; ehen = 1'b1;
        if (c == 18) ehs = 16'hB8B8;
        else         ehs = words[c-19];
        erdy = (c - 18) < (n_send + ur);
      end else if (c < tend + 4) begin
        elp_p = 2'b00; elp_n = 2'b00; ehen = 1'b1;
        ehs = trail;
        eur = (ur == 1) && (c == tend);
      end else if (c >= tend + 10) begin
        ebusy = 1'b0;
      end
      check($sformatf("%s ctl c%0d", name, c), ctl_now(),
            32'({elp_p, elp_n, ehen, erdy, ebusy, eur}));
      check($sformatf("%s hs c%0d", name, c), 32'(hs_data_o), 32'(ehs));
      if (c == 2) enable_i = 1'b0;
      if (w < n_send) begin
        valid_i = 1'b1;
        data_i  = words[w];
        last_i  = use_last && (w == n_send - 1);
      end else if (hold) begin
        valid_i = 1'b1;
        data_i  = next_word;
        last_i  = 1'b0;
      end else begin
        valid_i = !seen && !ready_o;
        last_i  = 1'b0;
      end
      if (ready_o && valid_i && w < n_send) w++;
      if (ready_o) seen = 1'b1;
    end
    enable_i = hold;
  endtask

  initial begin
    words[0] = 16'h2211;
    words[1] = 16'h4433;
    words[2] = 16'hA655;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    valid_i  = 1'b0;
    last_i   = 1'b0;
    data_i   = '0;

    repeat (2) @(negedge clk_i);
    check("reset ctl", ctl_now(), 32'h0000_00F0);
    check("reset hs", 32'(hs_data_o), 32'h0);
    rst_i = 1'b1;

    // enable low with valid high: must stay idle
    valid_i = 1'b1;
    data_i  = words[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check($sformatf("idle_noen ctl %0d", i), ctl_now(), 32'h0000_00F0);
    end

    run_burst(3, 1'b1, 16'h00FF, 1'b0, 16'h0, "basic");
    run_burst(1, 1'b0, 16'hFFFF, 1'b0, 16'h0, "bubble");
    run_burst(0, 1'b0, 16'h0000, 1'b0, 16'h0, "sync_ur");

    // reset asserted mid-DATA
    enable_i = 1'b1;
    valid_i  = 1'b1;
    last_i   = 1'b0;
    data_i   = 16'h1234;
    repeat (20) @(negedge clk_i);
    check("pre_rst hs", 32'(hs_data_o), 32'h1234);
    check("pre_rst ctl", ctl_now(), 32'h0000_000E);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst ctl", ctl_now(), 32'h0000_00F0);
    check("async_rst hs", 32'(hs_data_o), 32'h0);
    @(negedge clk_i);
    valid_i  = 1'b0;
    enable_i = 1'b0;
    rst_i    = 1'b1;
    @(negedge clk_i);
    check("post_rst idle", ctl_now(), 32'h0000_00F0);
    run_burst(3, 1'b1, 16'h00FF, 1'b0, 16'h0, "after_rst");

    // back-to-back: valid held through EXIT, second LP01 right after IDLE cycle
    run_burst(3, 1'b1, 16'h00FF, 1'b1, 16'h2211, "b2b_1");
    run_burst(3, 1'b1, 16'h00FF, 1'b0, 16'h0, "b2b_2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dphy_master_tx.md
Name: dphy_master_tx

Overview:
- Transmit-side D-PHY lane sequencer for the CSI-2 TX path; the counterpart of our D-PHY slave receive path.
- Accepts multi-lane byte words from the packet builder over a valid/ready stream.
- Drives per-lane low-power (LP) line states and HS byte data through the full HS burst: LP-11 → LP-01 → LP-00 → HS-zero → sync 0xB8 → payload → HS-trail → LP-11.
- Outputs feed per-lane serializers. The clock lane is handled elsewhere.

Parameters:
- DATA_LANES, 2, number of HS data lanes (1..4).
- LPX_CYCLES, 4, byte-clock cycles spent in LP-01 (≥1).
- PREPARE_CYCLES, 3, cycles spent in LP-00 before HS-zero (≥1).
- HS_ZERO_CYCLES, 10, cycles of 0x00 before the sync byte (≥1).
- TRAIL_CYCLES, 4, cycles of HS-trail after the last byte (≥1).
- EXIT_CYCLES, 6, cycles of LP-11 after the burst before a new request is accepted (≥1).

Ports:
- clk_i  input  1  byte clock; the only clock.
- rst_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  allows a new burst to start; sampled only in IDLE.
- data_i  input  [DATA_LANES-1:0][7:0]  payload word; lane i carries byte i.
- valid_i  input  1  data_i is valid.
- last_i  input  1  data_i is the final word of the burst.
- ready_o  output  1  word accepted on the edge where valid_i && ready_o.
- hs_data_o  output  [DATA_LANES-1:0][7:0]  HS byte per lane; LSB is transmitted first.
- hs_en_o  output  1  HS drivers enabled.
- lp_p_o  output  [DATA_LANES-1:0]  LP Dp level per lane.
- lp_n_o  output  [DATA_LANES-1:0]  LP Dn level per lane.
- busy_o  output  1  high in every state except IDLE.
- underrun_o  output  1  one-cycle pulse when the stream bubbles mid-burst.

Behaviour:
- All outputs are registered and change on the edge that enters a state. All lanes always carry identical LP states.
- Reset (rst_i low, asynchronous) forces:
  - state = IDLE
  - hs_data_o = 0, hs_en_o = 0
  - lp_p_o = all ones, lp_n_o = all ones
  - ready_o = 0, busy_o = 0, underrun_o = 0
  - all counters = 0
- Reset mid-burst aborts immediately to these values.
- State machine (counters are sized $clog2(max param + 1) and reload on each state entry):
  - IDLE: lp = 11, hs_en = 0. Moves to LP01 when enable_i && valid_i. The word is not consumed.
  - LP01: lp p = 0, n = 1. Lasts LPX_CYCLES, then LP00.
  - LP00: lp = 00. Lasts PREPARE_CYCLES, then HS_ZERO.
  - HS_ZERO: hs_en = 1, lp = 00, hs_data = 0x00 on all lanes. Lasts HS_ZERO_CYCLES, then SYNC.
  - SYNC: hs_data = 0xB8 on all lanes for exactly 1 cycle; ready_o = 1.
  - DATA: ready_o = 1.
- Word handling in SYNC and DATA:
  - valid_i && !last_i: the word appears on hs_data_o next cycle; state = DATA.
  - valid_i && last_i: the word appears next cycle; then state = TRAIL. ready_o is low from that edge on.
  - !valid_i (underrun): state = TRAIL directly; underrun_o pulses for 1 cycle; the trail is computed from the byte currently on hs_data_o.
- TRAIL: hs_en = 1, lp = 00, ready_o = 0.
  - Lane i drives {8{~b7}}, where b7 is bit 7 of that lane's final transmitted byte (last serialized bit, inverted). The final byte is captured in a register.
  - Lasts TRAIL_CYCLES, then EXIT.
- EXIT: hs_en = 0, hs_data = 0, lp = 11. Lasts EXIT_CYCLES, then IDLE. valid_i is ignored.
- enable_i deasserted mid-burst has no effect; the burst completes normally.
- Throughput: one word per cycle. The sender must keep valid_i high from SYNC until last_i.
- Start latency with defaults: valid_i sampled at edge 0 gives LP01 in cycles 1–4, LP00 in 5–7, HS_ZERO in 8–17, and ready_o first high in cycle 18 (SYNC).

Test Plan:
- Defaults, 2 lanes, 3 words {0x11,0x22},{0x33,0x44},{0x55,0xA6 last}, valid held high -> LP sequence 11/01×4/00×3. hs_data_o shows 0x00×10, 0xB8×1, then the 3 words on consecutive cycles. Trail ×4 is lane0 0xFF, lane1 0x00. Then lp = 11 for 6 cycles; busy_o drops in cycle 1+4+3+10+1+3+4+6 = 32.
- Bubble: valid_i dropped after the first word -> underrun_o pulses 1 cycle. TRAIL follows that word: lane0 = ~0x11[7] → 0xFF, lane1 → 0xFF. There is no third output word.
- Underrun in SYNC (valid_i low in cycle 18) -> underrun_o = 1, TRAIL = 0x00 on all lanes (0xB8 bit 7 = 1), no payload.
- enable_i = 0 with valid_i = 1 -> remains IDLE, lp = 11, ready_o = 0. Raising enable_i starts LP01 the next cycle.
- rst_i pulsed low during DATA -> outputs return to reset values asynchronously. After release: IDLE, and a new burst runs with full latency.
- Back-to-back bursts (valid_i held high across EXIT) -> the second LP01 begins exactly EXIT_CYCLES + 1 cycles after the first TRAIL ends. No word is lost.
